// File: rtl/decode_stage.sv
// RV32I decode stage: decodes fetch-side instructions into an ID/EX control bundle
// with valid/ready handshakes, load-use bubble insertion, flush and a stall counter.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [31:0]      if_instr,
  input  logic [XLEN-1:0]  if_pc,
  input  logic             flush,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [XLEN-1:0]  ex_pc,
  output logic [3:0]       ex_alu_sel,
  output logic [XLEN-1:0]  ex_imm,
  output logic             ex_use_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic             ex_rf_we,
  output logic             ex_mem_re,
  output logic             ex_mem_we,
  output logic [2:0]       ex_ls_width,
  output logic [3:0]       ex_jbl_op,
  output logic [1:0]       ex_sys,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] perf_stalls
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLT   = 4'd2;
  localparam logic [3:0] ALU_SLTU  = 4'd3;
  localparam logic [3:0] ALU_AND   = 4'd4;
  localparam logic [3:0] ALU_OR    = 4'd5;
  localparam logic [3:0] ALU_XOR   = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_LUI   = 4'd10;
  localparam logic [3:0] ALU_AUIPC = 4'd11;

  localparam logic [3:0] JBL_NONE = 4'd0;
  localparam logic [3:0] JBL_JAL  = 4'd1;
  localparam logic [3:0] JBL_JALR = 4'd2;
  localparam logic [3:0] JBL_BEQ  = 4'd3;
  localparam logic [3:0] JBL_BNE  = 4'd4;
  localparam logic [3:0] JBL_BLT  = 4'd5;
  localparam logic [3:0] JBL_BGE  = 4'd6;
  localparam logic [3:0] JBL_BLTU = 4'd7;
  localparam logic [3:0] JBL_BGEU = 4'd8;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      alu_sel;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rf_we;
    logic            mem_re;
    logic            mem_we;
    logic [2:0]      ls_width;
    logic [3:0]      jbl_op;
    logic [1:0]      sys;
    logic            illegal;
  } bundle_t;

  // Replicating bit 31 (XLEN-31) times avoids a zero-width replication at XLEN=32.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    sext32 = {{(XLEN-31){v[31]}}, v[30:0]};
  endfunction

  function automatic logic [3:0] f3_alu(input logic [2:0] f3);
    case (f3)
      3'd0:    f3_alu = ALU_ADD;
      3'd1:    f3_alu = ALU_SLL;
      3'd2:    f3_alu = ALU_SLT;
      3'd3:    f3_alu = ALU_SLTU;
      3'd4:    f3_alu = ALU_XOR;
      3'd5:    f3_alu = ALU_SRL;
      3'd6:    f3_alu = ALU_OR;
      3'd7:    f3_alu = ALU_AND;
      default: f3_alu = ALU_ADD;
    endcase
  endfunction

  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [6:0]      funct7_s;
  logic [4:0]      rs1_f_s;
  logic [4:0]      rs2_f_s;
  logic [4:0]      rd_f_s;
  logic [6:0]      sh_hi_s;
  logic [5:0]      shamt_s;
  logic [XLEN-1:0] imm_i_s;
  logic [XLEN-1:0] imm_s_s;
  logic [XLEN-1:0] imm_b_s;
  logic [XLEN-1:0] imm_u_s;
  logic [XLEN-1:0] imm_j_s;
  logic [XLEN-1:0] imm_sh_s;

  assign opcode_s = if_instr[6:0];
  assign funct3_s = if_instr[14:12];
  assign funct7_s = if_instr[31:25];
  assign rs1_f_s  = if_instr[19:15];
  assign rs2_f_s  = if_instr[24:20];
  assign rd_f_s   = if_instr[11:7];

  // RV64 shift-immediates borrow instr[25] as the sixth shamt bit.
  assign sh_hi_s  = (XLEN == 64) ? {if_instr[31:26], 1'b0} : if_instr[31:25];
  assign shamt_s  = (XLEN == 64) ? if_instr[25:20] : {1'b0, if_instr[24:20]};

  assign imm_i_s  = sext32({{20{if_instr[31]}}, if_instr[31:20]});
  assign imm_s_s  = sext32({{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]});
  assign imm_b_s  = sext32({{19{if_instr[31]}}, if_instr[31], if_instr[7],
                            if_instr[30:25], if_instr[11:8], 1'b0});
  assign imm_u_s  = sext32({if_instr[31:12], 12'h000});
  assign imm_j_s  = sext32({{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                            if_instr[20], if_instr[30:21], 1'b0});
  assign imm_sh_s = {{(XLEN-6){1'b0}}, shamt_s};

  bundle_t dec_s;
  bundle_t raw_s;
  logic    ill_s;
  logic    uses_rs1_s;
  logic    uses_rs2_s;

  // Combinational decode of the instruction presented by fetch.
  always_comb begin
    raw_s      = '0;
    ill_s      = 1'b0;
    uses_rs1_s = 1'b0;
    uses_rs2_s = 1'b0;
    case (opcode_s)
      OPC_LUI, OPC_AUIPC: begin
        raw_s.rd      = rd_f_s;
        raw_s.rf_we   = 1'b1;
        raw_s.use_imm = 1'b1;
        raw_s.imm     = imm_u_s;
        raw_s.alu_sel = (opcode_s == OPC_LUI) ? ALU_LUI : ALU_AUIPC;
      end
      OPC_JAL: begin
        raw_s.rd     = rd_f_s;
        raw_s.rf_we  = 1'b1;
        raw_s.imm    = imm_j_s;
        raw_s.jbl_op = JBL_JAL;
      end
      OPC_JALR: begin
        uses_rs1_s    = 1'b1;
        raw_s.rs1     = rs1_f_s;
        raw_s.rd      = rd_f_s;
        raw_s.rf_we   = 1'b1;
        raw_s.use_imm = 1'b1;
        raw_s.imm     = imm_i_s;
        raw_s.jbl_op  = JBL_JALR;
      end
      OPC_BRANCH: begin
        uses_rs1_s    = 1'b1;
        uses_rs2_s    = 1'b1;
        raw_s.rs1     = rs1_f_s;
        raw_s.rs2     = rs2_f_s;
        raw_s.imm     = imm_b_s;
        raw_s.alu_sel = ALU_SUB;
        case (funct3_s)
          3'd0:    raw_s.jbl_op = JBL_BEQ;
          3'd1:    raw_s.jbl_op = JBL_BNE;
          3'd4:    raw_s.jbl_op = JBL_BLT;
          3'd5:    raw_s.jbl_op = JBL_BGE;
          3'd6:    raw_s.jbl_op = JBL_BLTU;
          3'd7:    raw_s.jbl_op = JBL_BGEU;
          default: ill_s = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        uses_rs1_s     = 1'b1;
        raw_s.rs1      = rs1_f_s;
        raw_s.rd       = rd_f_s;
        raw_s.rf_we    = 1'b1;
        raw_s.mem_re   = 1'b1;
        raw_s.use_imm  = 1'b1;
        raw_s.imm      = imm_i_s;
        raw_s.ls_width = funct3_s;
        ill_s = (funct3_s == 3'd3) || (funct3_s == 3'd6) || (funct3_s == 3'd7);
      end
      OPC_STORE: begin
        uses_rs1_s     = 1'b1;
        uses_rs2_s     = 1'b1;
        raw_s.rs1      = rs1_f_s;
        raw_s.rs2      = rs2_f_s;
        raw_s.mem_we   = 1'b1;
        raw_s.use_imm  = 1'b1;
        raw_s.imm      = imm_s_s;
        raw_s.ls_width = funct3_s;
        ill_s = (funct3_s > 3'd2);
      end
      OPC_OPIMM: begin
        uses_rs1_s    = 1'b1;
        raw_s.rs1     = rs1_f_s;
        raw_s.rd      = rd_f_s;
        raw_s.rf_we   = 1'b1;
        raw_s.use_imm = 1'b1;
        raw_s.imm     = imm_i_s;
        raw_s.alu_sel = f3_alu(funct3_s);
        if (funct3_s == 3'd1) begin
          raw_s.imm = imm_sh_s;
          ill_s     = (sh_hi_s != 7'h00);
        end else if (funct3_s == 3'd5) begin
          raw_s.imm = imm_sh_s;
          if (sh_hi_s == 7'h20) begin
            raw_s.alu_sel = ALU_SRA;
          end else begin
            ill_s = (sh_hi_s != 7'h00);
          end
        end else begin
          raw_s.imm = imm_i_s;
        end
      end
      OPC_OP: begin
        uses_rs1_s    = 1'b1;
        uses_rs2_s    = 1'b1;
        raw_s.rs1     = rs1_f_s;
        raw_s.rs2     = rs2_f_s;
        raw_s.rd      = rd_f_s;
        raw_s.rf_we   = 1'b1;
        raw_s.alu_sel = f3_alu(funct3_s);
        if (funct7_s == 7'h00) begin
          ill_s = 1'b0;
        end else if (funct7_s == 7'h20 && funct3_s == 3'd0) begin
          raw_s.alu_sel = ALU_SUB;
        end else if (funct7_s == 7'h20 && funct3_s == 3'd5) begin
          raw_s.alu_sel = ALU_SRA;
        end else begin
          ill_s = 1'b1;
        end
      end
      OPC_FENCE: begin
        ill_s = 1'b0;
      end
      OPC_SYSTEM: begin
        if (if_instr[31:21] == 11'd0 && if_instr[19:7] == 13'd0) begin
          raw_s.sys = if_instr[20] ? 2'b10 : 2'b01;
        end else begin
          ill_s = 1'b1;
        end
      end
      default: ill_s = 1'b1;
    endcase
  end

  // An undecodable word travels as a bare flagged bundle with nothing enabled.
  always_comb begin
    dec_s = raw_s;
    if (ill_s || (if_instr[1:0] != 2'b11)) begin
      dec_s         = '0;
      dec_s.illegal = 1'b1;
    end else begin
      dec_s.rf_we = raw_s.rf_we & (raw_s.rd != 5'd0);
    end
    dec_s.pc = if_pc;
  end

  bundle_t          ex_q,    ex_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] perf_q,  perf_d;
  logic             advance_s;
  logic             hazard_s;

  assign advance_s = ~valid_q | ex_ready;
  assign hazard_s  = if_valid & valid_q & ex_q.mem_re & (ex_q.rd != 5'd0) &
                     ((uses_rs1_s & (rs1_f_s == ex_q.rd)) |
                      (uses_rs2_s & (rs2_f_s == ex_q.rd)));
  assign if_ready  = ~rst & (flush | (advance_s & ~hazard_s));

  // Next-state selection for the ID/EX register and the stall counter.
  always_comb begin
    ex_d    = ex_q;
    valid_d = valid_q;
    perf_d  = perf_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (advance_s && hazard_s) begin
      valid_d = 1'b0;
      if (perf_q != {CNT_W{1'b1}}) begin
        perf_d = perf_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        perf_d = perf_q;
      end
    end else if (advance_s) begin
      valid_d = if_valid & if_ready;
      ex_d    = dec_s;
    end else begin
      valid_d = valid_q;
    end
  end

  // ID/EX pipeline register and performance counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      valid_q <= 1'b0;
      perf_q  <= {CNT_W{1'b0}};
    end else begin
      ex_q    <= ex_d;
      valid_q <= valid_d;
      perf_q  <= perf_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = ex_q.pc;
  assign ex_alu_sel  = ex_q.alu_sel;
  assign ex_imm      = ex_q.imm;
  assign ex_use_imm  = ex_q.use_imm;
  assign ex_rs1      = ex_q.rs1;
  assign ex_rs2      = ex_q.rs2;
  assign ex_rd       = ex_q.rd;
  assign ex_rf_we    = ex_q.rf_we;
  assign ex_mem_re   = ex_q.mem_re;
  assign ex_mem_we   = ex_q.mem_we;
  assign ex_ls_width = ex_q.ls_width;
  assign ex_jbl_op   = ex_q.jbl_op;
  assign ex_sys      = ex_q.sys;
  assign ex_illegal  = ex_q.illegal;
  assign perf_stalls = perf_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a decode vector table plus hand-written
// handshake, hazard, flush, saturation and reset sequences.
module tb_decode_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst, if_valid, if_ready, flush, ex_valid, ex_ready;
  logic [31:0]      if_instr;
  logic [XLEN-1:0]  if_pc, ex_pc, ex_imm;
  logic [3:0]       ex_alu_sel, ex_jbl_op;
  logic             ex_use_imm, ex_rf_we, ex_mem_re, ex_mem_we, ex_illegal;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic [2:0]       ex_ls_width;
  logic [1:0]       ex_sys;
  logic [CNT_W-1:0] perf_stalls;

  int total = 0;
  int bad   = 0;

  decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .flush(flush), .ex_valid(ex_valid),
    .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_alu_sel(ex_alu_sel), .ex_imm(ex_imm),
    .ex_use_imm(ex_use_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rf_we(ex_rf_we), .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
    .ex_ls_width(ex_ls_width), .ex_jbl_op(ex_jbl_op), .ex_sys(ex_sys),
    .ex_illegal(ex_illegal), .perf_stalls(perf_stalls)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  alu;
    logic [31:0] imm;
    logic        use_imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rf_we, mem_re, mem_we;
    logic [2:0]  lsw;
    logic [3:0]  jbl;
    logic [1:0]  sys;
    logic        ill;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  localparam logic [31:0] I_LW     = 32'h0000A103;
  localparam logic [31:0] I_ADD_HZ = 32'h002101B3;
  localparam logic [31:0] I_ADD_NO = 32'h000001B3;
  localparam logic [31:0] I_ADDI5  = 32'h00500093;
  localparam logic [31:0] I_ADDI7  = 32'h00700113;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins);
    if_valid = v;
    if_instr = ins;
    if_pc    = if_pc + 32'd4;
  endtask

  initial begin
    vecs[0]  = '{32'h00500093, 4'd0,  32'h00000005, 1'b1, 5'd0, 5'd0, 5'd1,  1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 2'd0, 1'b0};
    vecs[1]  = '{32'hFE208CE3, 4'd1,  32'hFFFFFFF8, 1'b0, 5'd1, 5'd2, 5'd0,  1'b0, 1'b0, 1'b0, 3'd0, 4'd3, 2'd0, 1'b0};
    vecs[2]  = '{32'h0000A103, 4'd0,  32'h00000000, 1'b1, 5'd1, 5'd0, 5'd2,  1'b1, 1'b1, 1'b0, 3'd2, 4'd0, 2'd0, 1'b0};
    vecs[3]  = '{32'h00532623, 4'd0,  32'h0000000C, 1'b1, 5'd6, 5'd5, 5'd0,  1'b0, 1'b0, 1'b1, 3'd2, 4'd0, 2'd0, 1'b0};
    vecs[4]  = '{32'h123453B7, 4'd10, 32'h12345000, 1'b1, 5'd0, 5'd0, 5'd7,  1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 2'd0, 1'b0};
    vecs[5]  = '{32'h4071D213, 4'd9,  32'h00000007, 1'b1, 5'd3, 5'd0, 5'd4,  1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 2'd0, 1'b0};
    vecs[6]  = '{32'h407302B3, 4'd1,  32'h00000000, 1'b0, 5'd6, 5'd7, 5'd5,  1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 2'd0, 1'b0};
    vecs[7]  = '{32'hFFFFFFFF, 4'd0,  32'h00000000, 1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 2'd0, 1'b1};
    vecs[8]  = '{32'h00100073, 4'd0,  32'h00000000, 1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 2'd2, 1'b0};
    vecs[9]  = '{32'h00000073, 4'd0,  32'h00000000, 1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 2'd1, 1'b0};
    vecs[10] = '{32'h023100B3, 4'd0,  32'h00000000, 1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 2'd0, 1'b1};
    vecs[11] = '{32'h0000B103, 4'd0,  32'h00000000, 1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 2'd0, 1'b1};
    vecs[12] = '{32'h00108013, 4'd0,  32'h00000001, 1'b1, 5'd1, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 2'd0, 1'b0};
    vecs[13] = '{32'h02009093, 4'd0,  32'h00000000, 1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 2'd0, 1'b1};
    vecs[14] = '{32'h00500091, 4'd0,  32'h00000000, 1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 2'd0, 1'b1};
    vecs[15] = '{32'h0FF0000F, 4'd0,  32'h00000000, 1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 2'd0, 1'b0};
    vecs[16] = '{32'hFFF00093, 4'd0,  32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd1,  1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 2'd0, 1'b0};
    vecs[17] = '{32'h80000517, 4'd11, 32'h80000000, 1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 2'd0, 1'b0};
    vecs[18] = '{32'h00526263, 4'd1,  32'h00000004, 1'b0, 5'd4, 5'd5, 5'd0,  1'b0, 1'b0, 1'b0, 3'd0, 4'd7, 2'd0, 1'b0};
    vecs[19] = '{32'h00522263, 4'd0,  32'h00000000, 1'b0, 5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 2'd0, 1'b1};

    rst = 1'b1; if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h1000;
    flush = 1'b0; ex_ready = 1'b0;
    tick();
    chk("rst_if_ready", 64'(if_ready), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_perf", 64'(perf_stalls), 64'd0);
    chk("rst_imm", 64'(ex_imm), 64'd0);
    chk("rst_rd", 64'(ex_rd), 64'd0);

    ex_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, vecs[i].instr);
      #1;
      chk($sformatf("v%0d_if_ready", i), 64'(if_ready), 64'd1);
      tick();
      chk($sformatf("v%0d_valid", i), 64'(ex_valid), 64'd1);
      chk($sformatf("v%0d_pc", i), 64'(ex_pc), 64'(if_pc));
      chk($sformatf("v%0d_alu", i), 64'(ex_alu_sel), 64'(vecs[i].alu));
      chk($sformatf("v%0d_imm", i), 64'(ex_imm), 64'(vecs[i].imm));
      chk($sformatf("v%0d_use_imm", i), 64'(ex_use_imm), 64'(vecs[i].use_imm));
      chk($sformatf("v%0d_rs1", i), 64'(ex_rs1), 64'(vecs[i].rs1));
      chk($sformatf("v%0d_rs2", i), 64'(ex_rs2), 64'(vecs[i].rs2));
      chk($sformatf("v%0d_rd", i), 64'(ex_rd), 64'(vecs[i].rd));
      chk($sformatf("v%0d_rf_we", i), 64'(ex_rf_we), 64'(vecs[i].rf_we));
      chk($sformatf("v%0d_mem_re", i), 64'(ex_mem_re), 64'(vecs[i].mem_re));
      chk($sformatf("v%0d_mem_we", i), 64'(ex_mem_we), 64'(vecs[i].mem_we));
      chk($sformatf("v%0d_lsw", i), 64'(ex_ls_width), 64'(vecs[i].lsw));
      chk($sformatf("v%0d_jbl", i), 64'(ex_jbl_op), 64'(vecs[i].jbl));
      chk($sformatf("v%0d_sys", i), 64'(ex_sys), 64'(vecs[i].sys));
      chk($sformatf("v%0d_ill", i), 64'(ex_illegal), 64'(vecs[i].ill));
      drive(1'b0, 32'h0);
      tick();
    end
    chk("tbl_perf", 64'(perf_stalls), 64'd0);

    // load-use stall, then a non-dependent follower
    drive(1'b1, I_LW);
    tick();
    drive(1'b1, I_ADD_HZ);
    #1;
    chk("lu_if_ready_low", 64'(if_ready), 64'd0);
    tick();
    chk("lu_bubble", 64'(ex_valid), 64'd0);
    chk("lu_perf", 64'(perf_stalls), 64'd1);
    chk("lu_if_ready_back", 64'(if_ready), 64'd1);
    tick();
    chk("lu_add_valid", 64'(ex_valid), 64'd1);
    chk("lu_add_rd", 64'(ex_rd), 64'd3);
    chk("lu_add_rs1", 64'(ex_rs1), 64'd2);
    drive(1'b1, I_LW);
    tick();
    drive(1'b1, I_ADD_NO);
    #1;
    chk("nolu_if_ready", 64'(if_ready), 64'd1);
    tick();
    chk("nolu_valid", 64'(ex_valid), 64'd1);
    chk("nolu_rd", 64'(ex_rd), 64'd3);
    chk("nolu_perf", 64'(perf_stalls), 64'd1);
    drive(1'b0, 32'h0);
    tick();

    // backpressure
    drive(1'b1, I_ADDI5);
    tick();
    ex_ready = 1'b0;
    drive(1'b1, I_ADDI7);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_if_ready", k), 64'(if_ready), 64'd0);
      tick();
      chk($sformatf("bp%0d_valid", k), 64'(ex_valid), 64'd1);
      chk($sformatf("bp%0d_imm", k), 64'(ex_imm), 64'd5);
      chk($sformatf("bp%0d_rd", k), 64'(ex_rd), 64'd1);
    end
    ex_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(if_ready), 64'd1);
    tick();
    chk("bp_next_valid", 64'(ex_valid), 64'd1);
    chk("bp_next_imm", 64'(ex_imm), 64'd7);
    chk("bp_next_rd", 64'(ex_rd), 64'd2);
    drive(1'b0, 32'h0);
    tick();
    chk("bp_no_dup", 64'(ex_valid), 64'd0);

    // flush with backpressure, then flush racing a hazard
    drive(1'b1, I_ADDI5);
    tick();
    ex_ready = 1'b0;
    flush = 1'b1;
    drive(1'b1, I_ADDI7);
    #1;
    chk("fl_if_ready", 64'(if_ready), 64'd1);
    tick();
    chk("fl_valid", 64'(ex_valid), 64'd0);
    chk("fl_perf", 64'(perf_stalls), 64'd1);
    flush = 1'b0;
    drive(1'b0, 32'h0);
    tick();
    chk("fl_dropped", 64'(ex_valid), 64'd0);
    ex_ready = 1'b1;
    drive(1'b1, I_LW);
    tick();
    flush = 1'b1;
    drive(1'b1, I_ADD_HZ);
    tick();
    chk("flhz_valid", 64'(ex_valid), 64'd0);
    chk("flhz_perf", 64'(perf_stalls), 64'd1);
    flush = 1'b0;
    drive(1'b0, 32'h0);
    tick();

    // counter saturation: eight more stalls on a 3-bit counter
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, I_LW);
      tick();
      drive(1'b1, I_ADD_HZ);
      tick();
      tick();
      drive(1'b0, 32'h0);
      tick();
    end
    chk("sat_perf", 64'(perf_stalls), 64'd7);

    // reset mid-stream
    drive(1'b1, I_LW);
    tick();
    chk("mr_loaded", 64'(ex_valid), 64'd1);
    rst = 1'b1;
    drive(1'b1, I_ADDI5);
    #1;
    chk("mr_if_ready", 64'(if_ready), 64'd0);
    tick();
    chk("mr_valid", 64'(ex_valid), 64'd0);
    chk("mr_perf", 64'(perf_stalls), 64'd0);
    chk("mr_rd", 64'(ex_rd), 64'd0);
    rst = 1'b0;
    drive(1'b0, 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
